dbg_bus_arbiter: RTL and testbench

Shares the core's data bus between the CPU master and the debug master. The debug master can also halt the CPU on request. It sits between the datapath's bus master outputs and the system data bus interconnect, and it drives `ds_cpu_halt` into the datapath. Before granting the bus to the debug master, it waits for any in-flight LW stall to finish. While the CPU is halted, it suppresses the frozen CPU bus request so that no access repeats.

---
 rtl/dbg_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_dbg_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_bus_arbiter.sv
// dbg_bus_arbiter
//
// Purpose: shares the core data bus between the CPU master and the debug master.
// The debug master can also halt the CPU. The arbiter waits for any in-flight
// LW stall before it takes the bus. While the CPU is halted, it masks the
// frozen CPU request so that no access repeats.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   cpu_address/write_data/mode  CPU master request (reqw, reqs passed through)
//   stall_lw                     CPU is in the first cycle of an LW stall
//   cpu_read_data                bus return data to the CPU
//   ds_cpu_halt                  halts the datapath whenever the debug side owns the core
//   dbg_halt_req, dbg_req        debugger halt request and access request (levels)
//   dbg_we/address/write_data/reqw  debug command, sampled at accept
//   dbg_ack                      one-cycle completion pulse
//   dbg_read_data                last captured debug read data
//   dbg_halted                   CPU is parked in the halted state
//   bus_*                        muxed request to the system interconnect
//   bus_read_data                interconnect return data
module dbg_bus_arbiter #(
    parameter int unsigned READ_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic [1:0]  cpu_mode,
    input  logic [1:0]  cpu_reqw,
    input  logic        cpu_reqs,
    input  logic        stall_lw,
    output logic [31:0] cpu_read_data,
    output logic        ds_cpu_halt,
    input  logic        dbg_halt_req,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_address,
    input  logic [31:0] dbg_write_data,
    input  logic [1:0]  dbg_reqw,
    output logic        dbg_ack,
    output logic [31:0] dbg_read_data,
    output logic        dbg_halted,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [1:0]  bus_mode,
    output logic [1:0]  bus_reqw,
    output logic        bus_reqs,
    input  logic [31:0] bus_read_data
);

    // The counter only has to reach READ_CYCLES-1.
    localparam int unsigned CntW = (READ_CYCLES > 2) ? $clog2(READ_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(READ_CYCLES - 1);

    typedef enum logic [1:0] {StCpu, StHalted, StAcc, StResp} state_e;

    state_e          state_q;
    logic            cmd_we_q;
    logic [31:0]     cmd_address_q;
    logic [31:0]     cmd_write_data_q;
    logic [1:0]      cmd_reqw_q;
    logic [CntW-1:0] cnt_q;
    logic            ack_q;
    logic [31:0]     rd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StCpu;
            cmd_we_q         <= 1'b0;
            cmd_address_q    <= '0;
            cmd_write_data_q <= '0;
            cmd_reqw_q       <= '0;
            cnt_q            <= '0;
            ack_q            <= 1'b0;
            rd_q             <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StCpu: begin
                    // An LW in its first stall cycle must finish its second
                    // cycle on the CPU's bus, so both exits wait for it.
                    if (dbg_req && !stall_lw) begin
                        cmd_we_q         <= dbg_we;
                        cmd_address_q    <= dbg_address;
                        cmd_write_data_q <= dbg_write_data;
                        cmd_reqw_q       <= dbg_reqw;
                        cnt_q            <= '0;
                        state_q          <= StAcc;
                    end else if (dbg_halt_req && !stall_lw) begin
                        state_q <= StHalted;
                    end
                end
                StHalted: begin
                    if (dbg_req) begin
                        cmd_we_q         <= dbg_we;
                        cmd_address_q    <= dbg_address;
                        cmd_write_data_q <= dbg_write_data;
                        cmd_reqw_q       <= dbg_reqw;
                        cnt_q            <= '0;
                        state_q          <= StAcc;
                    end else if (!dbg_halt_req) begin
                        state_q <= StCpu;
                    end
                end
                StAcc: begin
                    if (cmd_we_q) begin
                        ack_q   <= 1'b1;
                        state_q <= StResp;
                    end else if (cnt_q == CntLast) begin
                        rd_q    <= bus_read_data;
                        ack_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    // dbg_req is deliberately ignored here: it forces one idle cycle.
                    state_q <= dbg_halt_req ? StHalted : StCpu;
                end
                default: state_q <= StCpu;
            endcase
        end
    end

    always_comb begin
        bus_address    = cpu_address;
        bus_write_data = cpu_write_data;
        bus_mode       = cpu_mode;
        bus_reqw       = cpu_reqw;
        bus_reqs       = cpu_reqs;
        case (state_q)
            // The frozen CPU request is masked so that it does not repeat.
            StHalted: bus_mode = 2'b00;
            StAcc: begin
                bus_address    = cmd_address_q;
                bus_write_data = cmd_write_data_q;
                bus_mode       = cmd_we_q ? 2'b10 : 2'b01;
                bus_reqw       = cmd_reqw_q;
                bus_reqs       = 1'b0;
            end
            StResp: begin
                bus_address    = cmd_address_q;
                bus_write_data = cmd_write_data_q;
                bus_mode       = 2'b00;
                bus_reqw       = cmd_reqw_q;
                bus_reqs       = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_read_data = bus_read_data;
    assign ds_cpu_halt   = (state_q != StCpu);
    assign dbg_halted    = (state_q == StHalted);
    assign dbg_ack       = ack_q;
    assign dbg_read_data = rd_q;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
module tb_dbg_bus_arbiter;

    localparam int unsigned RC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address, cpu_write_data;
    logic [1:0]  cpu_mode, cpu_reqw;
    logic        cpu_reqs, stall_lw;
    logic [31:0] cpu_read_data;
    logic        ds_cpu_halt;
    logic        dbg_halt_req, dbg_req, dbg_we;
    logic [31:0] dbg_address, dbg_write_data;
    logic [1:0]  dbg_reqw;
    logic        dbg_ack;
    logic [31:0] dbg_read_data;
    logic        dbg_halted;
    logic [31:0] bus_address, bus_write_data;
    logic [1:0]  bus_mode, bus_reqw;
    logic        bus_reqs;
    logic [31:0] bus_read_data;

    dbg_bus_arbiter #(.READ_CYCLES(RC)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_mode(cpu_mode), .cpu_reqw(cpu_reqw), .cpu_reqs(cpu_reqs),
        .stall_lw(stall_lw), .cpu_read_data(cpu_read_data), .ds_cpu_halt(ds_cpu_halt),
        .dbg_halt_req(dbg_halt_req), .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_address(dbg_address), .dbg_write_data(dbg_write_data), .dbg_reqw(dbg_reqw),
        .dbg_ack(dbg_ack), .dbg_read_data(dbg_read_data), .dbg_halted(dbg_halted),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_mode(bus_mode), .bus_reqw(bus_reqw), .bus_reqs(bus_reqs),
        .bus_read_data(bus_read_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the core, described as an access countdown.
    int          m_left;     // bus cycles of the debug access still to issue
    bit          m_halted;   // CPU parked with no access in flight
    bit          m_ack;      // this is the response cycle
    bit          m_we;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [1:0]  m_reqw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic mreset();
        m_left = 0; m_halted = 0; m_ack = 0; m_we = 0;
        m_addr = '0; m_wd = '0; m_rd = '0; m_reqw = '0;
    endtask

    task automatic maccept();
        m_we = dbg_we; m_addr = dbg_address; m_wd = dbg_write_data; m_reqw = dbg_reqw;
        m_left = dbg_we ? 1 : RC;
        m_halted = 0;
    endtask

    task automatic mstep();
        bit cpu_owned;
        cpu_owned = !m_halted && m_left == 0 && !m_ack;
        if (cpu_owned) begin
            if (dbg_req && !stall_lw) maccept();
            else if (dbg_halt_req && !stall_lw) m_halted = 1;
        end else if (m_halted) begin
            if (dbg_req) maccept();
            else if (!dbg_halt_req) m_halted = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (!m_we) m_rd = bus_read_data;
                m_ack = 1;
            end
        end else begin
            m_ack = 0;
            m_halted = dbg_halt_req;
        end
    endtask

    // Settle, then compare every output against the model.
    task automatic chk();
        bit cpu_owned;
        logic [1:0] emode;
        #1;
        if (!reset) mreset();
        cpu_owned = !m_halted && m_left == 0 && !m_ack;
        emode = cpu_owned ? cpu_mode : (m_left > 0) ? (m_we ? 2'b10 : 2'b01) : 2'b00;
        check("cpu_read_data", cpu_read_data, bus_read_data);
        check("ds_cpu_halt", 32'(ds_cpu_halt), 32'(!cpu_owned));
        check("dbg_halted", 32'(dbg_halted), 32'(m_halted));
        check("dbg_ack", 32'(dbg_ack), 32'(m_ack));
        check("dbg_read_data", dbg_read_data, m_rd);
        check("bus_mode", 32'(bus_mode), 32'(emode));
        if (cpu_owned || m_halted) begin
            check("bus_address", bus_address, cpu_address);
            check("bus_write_data", bus_write_data, cpu_write_data);
            check("bus_reqw", 32'(bus_reqw), 32'(cpu_reqw));
            check("bus_reqs", 32'(bus_reqs), 32'(cpu_reqs));
        end else if (m_left > 0) begin
            check("bus_address_dbg", bus_address, m_addr);
            check("bus_write_data_dbg", bus_write_data, m_wd);
            check("bus_reqw_dbg", 32'(bus_reqw), 32'(m_reqw));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) mreset();
        else mstep();
        @(negedge clk);
    endtask

    task automatic cycle();
        chk();
        tick();
    endtask

    initial begin
        int first_ack, last_ack, n_ack;
        reset = 0; cpu_address = '0; cpu_write_data = '0; cpu_mode = '0; cpu_reqw = '0;
        cpu_reqs = 0; stall_lw = 0; dbg_halt_req = 0; dbg_req = 0; dbg_we = 0;
        dbg_address = '0; dbg_write_data = '0; dbg_reqw = '0; bus_read_data = '0;
        mreset();
        @(negedge clk);

        // Reset values
        cpu_mode = 2'b01; cpu_address = 32'h123;
        chk();
        check("rst_ds_cpu_halt", 32'(ds_cpu_halt), 0);
        check("rst_dbg_read_data", dbg_read_data, 0);
        check("rst_bus_mode", 32'(bus_mode), 1);
        check("rst_bus_address", bus_address, 32'h123);
        tick();
        reset = 1; cpu_mode = 0;
        cycle();

        // Debug read while CPU idle
        dbg_req = 1; dbg_we = 0; dbg_address = 32'h4004; bus_read_data = 32'h5;
        chk(); check("rd_accept_halt", 32'(ds_cpu_halt), 0); tick();
        dbg_req = 0;
        for (int i = 0; i < 2; i++) begin
            chk();
            check("rd_bus_mode", 32'(bus_mode), 1);
            check("rd_bus_addr", bus_address, 32'h4004);
            check("rd_halt", 32'(ds_cpu_halt), 1);
            check("rd_no_ack", 32'(dbg_ack), 0);
            tick();
        end
        chk();
        check("rd_ack", 32'(dbg_ack), 1);
        check("rd_data", dbg_read_data, 32'h5);
        check("rd_resp_halt", 32'(ds_cpu_halt), 1);
        tick();
        chk(); check("rd_after_halt", 32'(ds_cpu_halt), 0); tick();

        // Request during an LW stall
        stall_lw = 1; cpu_mode = 2'b01; cpu_address = 32'h100; dbg_req = 1;
        dbg_we = 0; dbg_address = 32'h200;
        chk(); check("lw1_mode", 32'(bus_mode), 1); check("lw1_addr", bus_address, 32'h100);
        tick();
        stall_lw = 0;
        chk(); check("lw2_mode", 32'(bus_mode), 1); check("lw2_addr", bus_address, 32'h100);
        check("lw2_halt", 32'(ds_cpu_halt), 0);
        tick();
        dbg_req = 0; cpu_mode = 0;
        chk(); check("lw_acc_halt", 32'(ds_cpu_halt), 1); check("lw_acc_addr", bus_address, 32'h200);
        tick();
        for (int i = 0; i < 3; i++) cycle();
        bus_read_data = 32'h5;

        // Debug write
        dbg_req = 1; dbg_we = 1; dbg_address = 32'h4000; dbg_write_data = 32'h7;
        cycle();
        dbg_req = 0;
        chk();
        check("wr_mode", 32'(bus_mode), 2);
        check("wr_data", bus_write_data, 32'h7);
        check("wr_addr", bus_address, 32'h4000);
        tick();
        chk();
        check("wr_ack", 32'(dbg_ack), 1);
        check("wr_resp_mode", 32'(bus_mode), 0);
        check("wr_rd_unchanged", dbg_read_data, 32'h5);
        tick();
        cycle();

        // Halt suppression
        dbg_halt_req = 1; cpu_mode = 2'b10;
        chk(); check("h_pre_mode", 32'(bus_mode), 2); tick();
        for (int i = 0; i < 3; i++) begin
            chk();
            check("h_mode", 32'(bus_mode), 0);
            check("h_halted", 32'(dbg_halted), 1);
            tick();
        end
        dbg_halt_req = 0;
        cycle();
        chk(); check("h_release_mode", 32'(bus_mode), 2); check("h_release", 32'(dbg_halted), 0);
        tick();

        // Back-to-back reads while halted
        cpu_mode = 0; dbg_halt_req = 1;
        cycle();
        dbg_req = 1; dbg_we = 0; dbg_address = 32'h4000; bus_read_data = 32'h11;
        n_ack = 0; first_ack = -1; last_ack = -1;
        for (int i = 0; i < 8; i++) begin
            chk();
            check("b2b_halt", 32'(ds_cpu_halt), 1);
            if (dbg_ack) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                dbg_address = 32'h4008; bus_read_data = 32'h22;
            end
            tick();
        end
        dbg_req = 0;
        chk();
        check("b2b_acks", n_ack, 2);
        check("b2b_gap", last_ack - first_ack, 4);
        check("b2b_data", dbg_read_data, 32'h22);
        tick();
        dbg_halt_req = 0;
        cycle(); cycle();

        // Reset mid-read
        dbg_req = 1; dbg_we = 0; dbg_address = 32'h4010;
        cycle();
        dbg_req = 0; reset = 0; cpu_mode = 2'b01;
        chk();
        check("rr_halt", 32'(ds_cpu_halt), 0);
        check("rr_ack", 32'(dbg_ack), 0);
        check("rr_data", dbg_read_data, 0);
        check("rr_halted", 32'(dbg_halted), 0);
        check("rr_mode", 32'(bus_mode), 1);
        tick();
        cycle();
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            chk(); check("rr_no_ack", 32'(dbg_ack), 0); tick();
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cpu_address = $urandom; cpu_write_data = $urandom;
            cpu_mode = 2'($urandom_range(0, 2)); cpu_reqw = 2'($urandom); cpu_reqs = 1'($urandom);
            stall_lw = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) dbg_halt_req = !dbg_halt_req;
            if ($urandom_range(0, 3) == 0) dbg_req = !dbg_req;
            dbg_we = 1'($urandom); dbg_address = $urandom; dbg_write_data = $urandom;
            dbg_reqw = 2'($urandom); bus_read_data = $urandom;
            reset = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
